and_tree_sweep_ctrl: RTL and testbench

- Sequencer that exhaustively sweeps all input vectors of the four-input delayed AND-tree datapath (inputs m, n, p, q; output out).
- For each vector: drives it, waits a programmable settle interval covering the tree's propagation delay, samples out, and checks it against the expected AND of all inputs.
- Reports per-vector samples, a mismatch count, and the first failing vector.
- Sits between a test/config master (start/abort) and the datapath under check.

---
 rtl/and_tree_sweep_ctrl.sv | 172 +++++++++++++++++
 tb/tb_and_tree_sweep_ctrl.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/and_tree_sweep_ctrl.sv
// and_tree_sweep_ctrl
//
// Drives every WIDTH-bit vector, from 0 to 2^WIDTH-1, into a delayed AND-tree datapath. For each
// vector it holds the vector for a settle interval, samples the datapath output and compares it
// with the AND of all vector bits. It counts mismatches and records the lowest failing vector.
//
// Ports
//   clk           clock; all state updates on the rising edge
//   rst           synchronous active-high reset; overrides start and abort
//   start         begin a sweep; honoured only while idle
//   abort         stop a running sweep without pulsing done
//   dut_out       datapath output under check
//   vec_out       vector driven to the datapath (msb = m ... lsb = q)
//   busy          high while a sweep is in progress
//   done          one-cycle pulse when a sweep completes
//   sample_valid  one-cycle pulse per sampled vector
//   sample_vec    vector that belongs to sample_bit
//   sample_bit    captured dut_out
//   err_cnt       mismatch count of the current or last sweep
//   err_flag      at least one mismatch in the current or last sweep
//   first_err_vec lowest mismatching vector; meaningful only when err_flag is set
module and_tree_sweep_ctrl #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned SETTLE = 2   // legal range 1..255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             dut_out,
   output logic [WIDTH-1:0] vec_out,
   output logic             busy,
   output logic             done,
   output logic             sample_valid,
   output logic [WIDTH-1:0] sample_vec,
   output logic             sample_bit,
   output logic [WIDTH:0]   err_cnt,
   output logic             err_flag,
   output logic [WIDTH-1:0] first_err_vec
);

   typedef enum logic [1:0] {StIdle, StWait, StSample, StDone} state_e;

   // WAIT leaves on this count, so the vector is held SETTLE cycles plus the capture cycle.
   localparam logic [7:0] CntLast = 8'(SETTLE - 1);

   state_e           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] vec_q, vec_d;
   logic [WIDTH-1:0] sample_vec_q, sample_vec_d;
   logic [WIDTH-1:0] first_err_q, first_err_d;
   logic [WIDTH:0]   err_cnt_q, err_cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             sample_valid_q, sample_valid_d;
   logic             sample_bit_q, sample_bit_d;
   logic             err_flag_q, err_flag_d;
   logic             expected;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      vec_d          = vec_q;
      sample_vec_d   = sample_vec_q;
      first_err_d    = first_err_q;
      err_cnt_d      = err_cnt_q;
      busy_d         = busy_q;
      err_flag_d     = err_flag_q;
      sample_bit_d   = sample_bit_q;
      done_d         = 1'b0;
      sample_valid_d = 1'b0;
      expected       = &vec_q;

      unique case (state_q)
         StIdle: begin
            // abort wins over a simultaneous start
            if (start && !abort) begin
               vec_d       = '0;
               cnt_d       = '0;
               err_cnt_d   = '0;
               err_flag_d  = 1'b0;
               first_err_d = '0;
               busy_d      = 1'b1;
               state_d     = StWait;
            end
         end

         StWait: begin
            if (abort) begin
               busy_d  = 1'b0;
               state_d = StIdle;
            end else if (cnt_q == CntLast) begin
               state_d = StSample;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         StSample: begin
            if (abort) begin
               busy_d  = 1'b0;
               state_d = StIdle;
            end else begin
               sample_valid_d = 1'b1;
               sample_bit_d   = dut_out;
               sample_vec_d   = vec_q;
               if (dut_out != expected) begin
                  err_cnt_d  = err_cnt_q + (WIDTH + 1)'(1);
                  err_flag_d = 1'b1;
                  // vectors rise monotonically, so the first mismatch is the lowest one
                  if (!err_flag_q) first_err_d = vec_q;
               end
               if (&vec_q) begin
                  state_d = StDone;
               end else begin
                  vec_d   = vec_q + WIDTH'(1);
                  cnt_d   = '0;
                  state_d = StWait;
               end
            end
         end

         StDone: begin
            // start and abort are both ignored here
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         cnt_q          <= '0;
         vec_q          <= '0;
         sample_vec_q   <= '0;
         first_err_q    <= '0;
         err_cnt_q      <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         sample_valid_q <= 1'b0;
         sample_bit_q   <= 1'b0;
         err_flag_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         vec_q          <= vec_d;
         sample_vec_q   <= sample_vec_d;
         first_err_q    <= first_err_d;
         err_cnt_q      <= err_cnt_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         sample_valid_q <= sample_valid_d;
         sample_bit_q   <= sample_bit_d;
         err_flag_q     <= err_flag_d;
      end
   end

   assign vec_out       = vec_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign sample_valid  = sample_valid_q;
   assign sample_vec    = sample_vec_q;
   assign sample_bit    = sample_bit_q;
   assign err_cnt       = err_cnt_q;
   assign err_flag      = err_flag_q;
   assign first_err_vec = first_err_q;

endmodule

// File: tb/tb_and_tree_sweep_ctrl.sv
`timescale 1ns/1ps
module tb_and_tree_sweep_ctrl;
   localparam int W    = 4;
   localparam int VMAX = (1 << W) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1, start = 1'b0, abort = 1'b0, sel = 1'b0;
   int   dp_mode = 0;  // 0: AND tree with dp_lat cycles latency, 1: stuck 0, 2: stuck 1
   int   dp_lat  = 0;
   int   edge_n  = 0;
   int   checks  = 0, errors = 0;
   int   pv_a    = 0, pv_b = 0;  // vector each controller holds while idle

   // instance a: SETTLE=2, instance b: SETTLE=5; sel picks which one is exercised
   logic [W-1:0] vec_a, svec_a, fe_a, vec_b, svec_b, fe_b;
   logic         busy_a, done_a, sv_a, sbit_a, ef_a, dout_a, start_a;
   logic         busy_b, done_b, sv_b, sbit_b, ef_b, dout_b, start_b;
   logic [W:0]   ec_a, ec_b;
   logic [7:0]   hist_a = '0, hist_b = '0;

   assign start_a = start & ~sel;
   assign start_b = start & sel;

   function automatic logic dp_model(input logic [W-1:0] v, input logic [7:0] h,
                                     input int mode, input int lat);
      if (mode == 1) return 1'b0;
      if (mode == 2) return 1'b1;
      if (lat == 0) return &v;
      return h[lat-1];
   endfunction

   assign dout_a = dp_model(vec_a, hist_a, dp_mode, dp_lat);
   assign dout_b = dp_model(vec_b, hist_b, dp_mode, dp_lat);

   always @(posedge clk) begin
      hist_a <= {hist_a[6:0], &vec_a};
      hist_b <= {hist_b[6:0], &vec_b};
      edge_n <= edge_n + 1;
   end

   and_tree_sweep_ctrl #(.WIDTH(W), .SETTLE(2)) u_dut (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort), .dut_out(dout_a),
      .vec_out(vec_a), .busy(busy_a), .done(done_a), .sample_valid(sv_a),
      .sample_vec(svec_a), .sample_bit(sbit_a), .err_cnt(ec_a), .err_flag(ef_a),
      .first_err_vec(fe_a)
   );

   and_tree_sweep_ctrl #(.WIDTH(W), .SETTLE(5)) u_dut5 (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort), .dut_out(dout_b),
      .vec_out(vec_b), .busy(busy_b), .done(done_b), .sample_valid(sv_b),
      .sample_vec(svec_b), .sample_bit(sbit_b), .err_cnt(ec_b), .err_flag(ef_b),
      .first_err_vec(fe_b)
   );

   logic [W-1:0] o_vec, o_svec, o_fe;
   logic         o_busy, o_done, o_sv, o_sbit, o_ef;
   logic [W:0]   o_ec;
   assign o_vec  = sel ? vec_b  : vec_a;
   assign o_svec = sel ? svec_b : svec_a;
   assign o_fe   = sel ? fe_b   : fe_a;
   assign o_busy = sel ? busy_b : busy_a;
   assign o_done = sel ? done_b : done_a;
   assign o_sv   = sel ? sv_b   : sv_a;
   assign o_sbit = sel ? sbit_b : sbit_a;
   assign o_ef   = sel ? ef_b   : ef_a;
   assign o_ec   = sel ? ec_b   : ec_a;

   // event log: edge index at which each pulse was asserted
   int           s_edge[$];
   logic [W-1:0] s_vec[$];
   logic         s_bit[$];
   int           d_edge[$];
   always @(negedge clk) begin
      if (o_sv === 1'b1) begin
         s_edge.push_back(edge_n);
         s_vec.push_back(o_svec);
         s_bit.push_back(o_sbit);
      end
      if (o_done === 1'b1) d_edge.push_back(edge_n);
   end

   // Reference: vector presented r cycles after the start edge. Vector v is sampled at
   // r = (v+1)(s+1), so it is on the bus for r in [v(s+1), (v+1)(s+1)).
   function automatic int vec_at(input int r, input int s, input int pv);
      if (r < 0) return pv;
      if (r / (s + 1) > VMAX) return VMAX;
      return r / (s + 1);
   endfunction

   // Bit the controller captures for vector v: the datapath shows the vector that was on the
   // bus lat cycles before the cycle preceding the sampling edge.
   function automatic logic exp_bit(input int v, input int s, input int mode, input int lat,
                                    input int pv);
      if (mode == 1) return 1'b0;
      if (mode == 2) return 1'b1;
      return logic'(vec_at((v + 1) * (s + 1) - 1 - lat, s, pv) == VMAX);
   endfunction

   function automatic int exp_errs(input int upto, input int s, input int mode, input int lat,
                                   input int pv, output int first_v);
      int n = 0;
      first_v = 0;
      for (int v = 0; v < upto; v++) begin
         if (exp_bit(v, s, mode, lat, pv) != logic'(v == VMAX)) begin
            if (n == 0) first_v = v;
            n++;
         end
      end
      return n;
   endfunction

   task automatic wait_sample(input int v, output int ok);
      int n = 0;
      while (!(o_sv === 1'b1 && o_svec === W'(v)) && n < 200) begin
         @(negedge clk);
         n++;
      end
      ok = (n < 200) ? 1 : 0;
   endtask

   task automatic run_sweep(input string name, input int mode, input int lat);
      int s, k, n, ee, fv, pv, busy_ok;
      s  = sel ? 5 : 2;
      pv = sel ? pv_b : pv_a;
      dp_mode = mode;
      dp_lat  = lat;
      repeat (6) @(negedge clk);
      s_edge.delete(); s_vec.delete(); s_bit.delete(); d_edge.delete();
      start = 1'b1;
      k = edge_n + 1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (o_busy !== 1'b1 || o_vec !== '0 || o_ec !== '0 || o_ef !== 1'b0) begin
         errors++;
         $display("FAIL %s start: busy=%b vec=%0d err_cnt=%0d err_flag=%b, want 1 0 0 0",
                  name, o_busy, o_vec, o_ec, o_ef);
      end
      busy_ok = 1;
      n = 0;
      while (o_done !== 1'b1 && n < 20 * (s + 1)) begin
         if (o_busy !== 1'b1) busy_ok = 0;
         @(negedge clk);
         n++;
      end
      checks++;
      if (o_done !== 1'b1) begin
         errors++;
         $display("FAIL %s done timeout: done=%b after %0d cycles, want 1", name, o_done, n);
      end
      checks++;
      if (busy_ok == 0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy window: held=%0d busy_at_done=%b, want 1 0", name, busy_ok,
                  o_busy);
      end
      @(negedge clk);
      checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL %s after done: done=%b busy=%b, want 0 0", name, o_done, o_busy);
      end
      checks++;
      if (s_edge.size() != VMAX + 1) begin
         errors++;
         $display("FAIL %s sample count: got %0d, want %0d", name, s_edge.size(), VMAX + 1);
      end
      for (int v = 0; v < s_edge.size() && v <= VMAX; v++) begin
         checks++;
         if (s_edge[v] != k + (v + 1) * (s + 1) || s_vec[v] !== W'(v) ||
             s_bit[v] !== exp_bit(v, s, mode, lat, pv)) begin
            errors++;
            $display("FAIL %s sample %0d: edge=%0d vec=%0d bit=%b, want %0d %0d %b", name, v,
                     s_edge[v] - k, s_vec[v], s_bit[v], (v + 1) * (s + 1), v,
                     exp_bit(v, s, mode, lat, pv));
         end
      end
      checks++;
      if (d_edge.size() != 1 || d_edge[0] != k + (VMAX + 1) * (s + 1) + 1) begin
         errors++;
         $display("FAIL %s done edge: pulses=%0d edge=%0d, want 1 %0d", name, d_edge.size(),
                  (d_edge.size() > 0) ? d_edge[0] - k : -1, (VMAX + 1) * (s + 1) + 1);
      end
      ee = exp_errs(VMAX + 1, s, mode, lat, pv, fv);
      checks++;
      if (o_ec !== (W + 1)'(ee) || o_ef !== logic'(ee > 0) ||
          (ee > 0 && o_fe !== W'(fv)) || o_vec !== W'(VMAX)) begin
         errors++;
         $display("FAIL %s result: err_cnt=%0d flag=%b first=%0d vec=%0d, want %0d %b %0d %0d",
                  name, o_ec, o_ef, o_fe, o_vec, ee, ee > 0, fv, VMAX);
      end
      if (sel) pv_b = VMAX; else pv_a = VMAX;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; abort = 1'b0; sel = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         sel = logic'(i);
         #1;
         checks++;
         if (o_busy !== 1'b0 || o_vec !== '0 || o_done !== 1'b0 || o_sv !== 1'b0 ||
             o_svec !== '0 || o_sbit !== 1'b0 || o_ec !== '0 || o_ef !== 1'b0 || o_fe !== '0)
         begin
            errors++;
            $display("FAIL reset inst%0d: busy=%b vec=%0d done=%b sv=%b ec=%0d ef=%b, want 0s",
                     i, o_busy, o_vec, o_done, o_sv, o_ec, o_ef);
         end
      end
      sel = 1'b0; start = 1'b0; rst = 1'b0;
      @(negedge clk);
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset release: busy=%b, want 0", o_busy);
      end
      pv_a = 0; pv_b = 0;
   endtask

   task automatic test_golden();
      sel = 1'b0;
      run_sweep("golden_lat0", 0, 0);
      run_sweep("golden_lat2", 0, 2);
   endtask

   task automatic test_stuck();
      sel = 1'b0;
      run_sweep("stuck0", 1, 0);
      checks++;
      if (o_ec !== 5'd1 || o_ef !== 1'b1 || o_fe !== 4'hF) begin
         errors++;
         $display("FAIL stuck0 totals: ec=%0d ef=%b fe=%0d, want 1 1 15", o_ec, o_ef, o_fe);
      end
      run_sweep("stuck1", 2, 0);
      checks++;
      if (o_ec !== 5'd15 || o_ef !== 1'b1 || o_fe !== 4'h0) begin
         errors++;
         $display("FAIL stuck1 totals: ec=%0d ef=%b fe=%0d, want 15 1 0", o_ec, o_ef, o_fe);
      end
   endtask

   task automatic test_latency();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      pv_a = 0; pv_b = 0;
      sel = 1'b0;
      run_sweep("lat4_settle2", 0, 4);
      checks++;
      if (o_ec !== 5'd1 || o_fe !== 4'hF) begin
         errors++;
         $display("FAIL lat4_settle2 totals: ec=%0d fe=%0d, want 1 15", o_ec, o_fe);
      end
      sel = 1'b1;
      run_sweep("lat4_settle5", 0, 4);
      sel = 1'b0;
   endtask

   task automatic test_abort_at5();
      int ok, n;
      sel = 1'b0; dp_mode = 2; dp_lat = 0;
      repeat (6) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_sample(5, ok);
      checks++;
      if (ok == 0) begin
         errors++;
         $display("FAIL abort5 wait: sample 5 seen=%0d, want 1", ok);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_sv !== 1'b0 || o_ec !== 5'd6 ||
          o_ef !== 1'b1 || o_fe !== 4'h0 || o_vec !== 4'd6) begin
         errors++;
         $display("FAIL abort5: busy=%b done=%b sv=%b ec=%0d fe=%0d vec=%0d, want 0 0 0 6 0 6",
                  o_busy, o_done, o_sv, o_ec, o_fe, o_vec);
      end
      n = 0;
      repeat (60) begin
         @(negedge clk);
         if (o_done === 1'b1 || o_busy === 1'b1 || o_sv === 1'b1) n++;
      end
      checks++;
      if (n != 0 || o_ec !== 5'd6) begin
         errors++;
         $display("FAIL abort5 hold: activity=%0d ec=%0d, want 0 6", n, o_ec);
      end
      pv_a = 6;
      run_sweep("restart_after_abort", 0, 0);
   endtask

   task automatic test_abort_random();
      int s, j, m, ee, fv, pv, mode, lat;
      for (int it = 0; it < 4; it++) begin
         sel  = 1'($urandom_range(1, 0));
         s    = sel ? 5 : 2;
         pv   = sel ? pv_b : pv_a;
         mode = $urandom_range(2, 0);
         lat  = $urandom_range(4, 0);
         j    = $urandom_range((VMAX + 1) * (s + 1), 1);
         dp_mode = mode; dp_lat = lat;
         repeat (6) @(negedge clk);
         s_edge.delete(); s_vec.delete(); s_bit.delete(); d_edge.delete();
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         repeat (j - 1) @(negedge clk);
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
         m = 0;
         for (int v = 0; v <= VMAX; v++) if ((v + 1) * (s + 1) < j) m++;
         ee = exp_errs(m, s, mode, lat, pv, fv);
         @(negedge clk);
         checks++;
         if (o_busy !== 1'b0 || s_edge.size() != m || d_edge.size() != 0 ||
             o_vec !== W'(m) || o_ec !== (W + 1)'(ee) || o_ef !== logic'(ee > 0) ||
             (ee > 0 && o_fe !== W'(fv))) begin
            errors++;
            $display("FAIL abort_rand j=%0d s=%0d: busy=%b samples=%0d dones=%0d vec=%0d",
                     j, s, o_busy, s_edge.size(), d_edge.size(), o_vec,
                     " ec=%0d fe=%0d, want 0 %0d 0 %0d %0d %0d", o_ec, o_fe, m, m, ee, fv);
         end
         if (sel) pv_b = m; else pv_a = m;
      end
      sel = 1'b0;
   endtask

   task automatic test_idle_start_abort();
      sel = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      checks++;
      if (o_busy !== 1'b0 || o_vec !== W'(pv_a)) begin
         errors++;
         $display("FAIL idle start+abort: busy=%b vec=%0d, want 0 %0d", o_busy, o_vec, pv_a);
      end
   endtask

   task automatic test_done_cycle();
      int ok;
      sel = 1'b0; dp_mode = 0; dp_lat = 0;
      repeat (6) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_sample(VMAX, ok);
      start = 1'b1; abort = 1'b1;  // both land on the DONE edge
      @(negedge clk);
      checks++;
      if (ok == 0 || o_done !== 1'b1 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL done cycle: seen=%0d done=%b busy=%b, want 1 1 0", ok, o_done, o_busy);
      end
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_ec !== '0) begin
         errors++;
         $display("FAIL done no restart: busy=%b done=%b ec=%0d, want 0 0 0", o_busy, o_done,
                  o_ec);
      end
      pv_a = VMAX;
   endtask

   task automatic test_start_mid_rst();
      int ok, k, n;
      sel = 1'b0; dp_mode = 2; dp_lat = 0;
      repeat (6) @(negedge clk);
      start = 1'b1;
      k = edge_n + 1;
      @(negedge clk);
      start = 1'b0;
      wait_sample(7, ok);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_sample(9, ok);
      checks++;
      if (ok == 0 || edge_n != k + 10 * 3 || o_ec !== 5'd10) begin
         errors++;
         $display("FAIL mid start ignored: seen=%0d edge=%0d ec=%0d, want 1 30 10", ok,
                  edge_n - k, o_ec);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (o_busy !== 1'b0 || o_vec !== '0 || o_done !== 1'b0 || o_sv !== 1'b0 ||
          o_svec !== '0 || o_sbit !== 1'b0 || o_ec !== '0 || o_ef !== 1'b0 || o_fe !== '0) begin
         errors++;
         $display("FAIL mid rst: busy=%b vec=%0d sv=%b svec=%0d ec=%0d ef=%b, want all 0",
                  o_busy, o_vec, o_sv, o_svec, o_ec, o_ef);
      end
      n = 0;
      repeat (60) begin
         @(negedge clk);
         if (o_done === 1'b1 || o_busy === 1'b1) n++;
      end
      checks++;
      if (n != 0) begin
         errors++;
         $display("FAIL mid rst quiet: activity=%0d, want 0", n);
      end
      pv_a = 0; pv_b = 0;
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         sel = 1'($urandom_range(1, 0));
         run_sweep("random", $urandom_range(2, 0), $urandom_range(4, 0));
      end
      sel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_golden();
      test_stuck();
      test_latency();
      test_abort_at5();
      test_abort_random();
      test_idle_start_abort();
      test_done_cycle();
      test_start_mid_rst();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
